// File: rtl/cis_seq_pkg.sv
// Shared types for the CIS readout sequencer: FSM states, pattern
// phases and the step-length clamp helper.
package cis_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CCD_RESET,
    INTEG,
    SKIP,
    WAIT_EOC,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    PH_RESET,
    PH_INTEG,
    PH_SKIP
  } phase_e;

  // Zero means one step; anything past the pattern depth is cut to it.
  function automatic int unsigned len_clamp(
    int unsigned len,
    int unsigned max_len
  );
    if (len == 0) return 1;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/cis_clk_div.sv
// Tick generator: one-clk tick every clk_div+1 clks.
// Ports: clk, reset, restart (sync count clear), clk_div, tick.
module cis_clk_div #(
  parameter int DIV_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic [DIV_W-1:0] clk_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // >= so a divider lowered below the running count wraps at once.
  assign tick = !restart && (cnt >= clk_div);

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cis_seq_ctrl.sv
// CIS readout sequencer: replays per-phase patterns onto sig_out,
// scans pixels with ADC EOC handshake/timeout, abort and status.
module cis_seq_ctrl #(
  parameter int NUM_SIGNALS = 9,
  parameter int PATTERN_LEN = 16,
  parameter int LEN_W       = 5,
  parameter int NUM_PIXELS  = 16,
  parameter int SKIP_W      = 14,
  parameter int DIV_W       = 10,
  parameter int EOC_TIMEOUT = 1023,
  parameter logic [NUM_SIGNALS-1:0] IDLE_LEVEL = '0
) (
  input  logic clk,
  input  logic reset,
  input  logic [DIV_W-1:0] clk_div,
  input  logic global_shutter,
  input  logic integration,
  input  logic abort,
  input  logic [SKIP_W-1:0] skip_samples,
  input  logic [LEN_W-1:0] len_reset,
  input  logic [LEN_W-1:0] len_integ,
  input  logic [LEN_W-1:0] len_skip,
  input  logic [NUM_SIGNALS-1:0][PATTERN_LEN-1:0] pattern_reset,
  input  logic [NUM_SIGNALS-1:0][PATTERN_LEN-1:0] pattern_integ,
  input  logic [NUM_SIGNALS-1:0][PATTERN_LEN-1:0] pattern_skip,
  input  logic adc_eoc,
  output logic [NUM_SIGNALS-1:0] sig_out,
  output logic row_rst,
  output logic row_clk,
  output logic [$clog2(NUM_PIXELS)-1:0] pixel_idx,
  output logic busy,
  output logic frame_done,
  output logic eoc_err
);
  import cis_seq_pkg::*;

  localparam int IDX_W = $clog2(PATTERN_LEN);
  localparam int PIX_W = $clog2(NUM_PIXELS);
  localparam int TMO_W = $clog2(EOC_TIMEOUT + 1);

  typedef logic [NUM_SIGNALS-1:0] sig_t;

  state_e            state;
  logic              tick;
  logic [LEN_W-1:0]  step;
  logic [LEN_W-1:0]  lr;
  logic [LEN_W-1:0]  li;
  logic [LEN_W-1:0]  ls;
  logic [SKIP_W-1:0] skip_lat;
  logic [SKIP_W-1:0] skip_cnt;
  logic [TMO_W-1:0]  tmo;

  cis_clk_div #(.DIV_W(DIV_W)) u_div (
    .clk     (clk),
    .reset   (reset),
    .restart (abort),
    .clk_div (clk_div),
    .tick    (tick)
  );

  assign busy = (state != IDLE);

  function automatic sig_t pat_col(phase_e ph, logic [IDX_W-1:0] k);
    sig_t c;
    c = '0;
    for (int s = 0; s < NUM_SIGNALS; s++) begin
      unique case (ph)
        PH_RESET: c[s] = pattern_reset[s][k];
        PH_INTEG: c[s] = pattern_integ[s][k];
        default:  c[s] = pattern_skip[s][k];
      endcase
    end
    return c;
  endfunction

  always_ff @(posedge clk) begin
    frame_done <= 1'b0;
    if (reset) begin
      state     <= IDLE;
      step      <= '0;
      lr        <= LEN_W'(1);
      li        <= LEN_W'(1);
      ls        <= LEN_W'(1);
      skip_lat  <= SKIP_W'(1);
      skip_cnt  <= '0;
      tmo       <= '0;
      sig_out   <= IDLE_LEVEL;
      row_rst   <= 1'b1;
      row_clk   <= 1'b0;
      pixel_idx <= '0;
      eoc_err   <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      step      <= '0;
      tmo       <= '0;
      sig_out   <= IDLE_LEVEL;
      row_clk   <= 1'b0;
      pixel_idx <= '0;
    end else if (tick) begin
      row_rst <= 1'b0;
      row_clk <= 1'b0;
      unique case (state)
        IDLE: begin
          if (integration) begin
            lr        <= LEN_W'(len_clamp(32'(len_reset), PATTERN_LEN));
            li        <= LEN_W'(len_clamp(32'(len_integ), PATTERN_LEN));
            ls        <= LEN_W'(len_clamp(32'(len_skip), PATTERN_LEN));
            skip_lat  <= (skip_samples == '0) ? SKIP_W'(1) : skip_samples;
            eoc_err   <= 1'b0;
            pixel_idx <= '0;
            step      <= '0;
            state     <= CCD_RESET;
            sig_out   <= pat_col(PH_RESET, '0);
          end
        end
        CCD_RESET: begin
          if (step == lr - 1'b1) begin
            state   <= INTEG;
            step    <= '0;
            sig_out <= pat_col(PH_INTEG, '0);
          end else begin
            step    <= step + 1'b1;
            sig_out <= pat_col(PH_RESET, IDX_W'(step + 1'b1));
          end
        end
        INTEG: begin
          if (step == '0 && integration) begin
            step <= '0;
          end else if (step == li - 1'b1) begin
            state    <= SKIP;
            step     <= '0;
            skip_cnt <= skip_lat;
            sig_out  <= pat_col(PH_SKIP, '0);
          end else begin
            step    <= step + 1'b1;
            sig_out <= pat_col(PH_INTEG, IDX_W'(step + 1'b1));
          end
        end
        SKIP: begin
          if (step != ls - 1'b1) begin
            step    <= step + 1'b1;
            sig_out <= pat_col(PH_SKIP, IDX_W'(step + 1'b1));
          end else if (skip_cnt > SKIP_W'(1)) begin
            skip_cnt <= skip_cnt - 1'b1;
            step     <= '0;
            sig_out  <= pat_col(PH_SKIP, '0);
          end else if (global_shutter &&
                       pixel_idx != PIX_W'(NUM_PIXELS - 1)) begin
            state <= WAIT_EOC;
            tmo   <= '0;
          end else begin
            state   <= DONE;
            row_clk <= 1'b1;
          end
        end
        WAIT_EOC: begin
          if (adc_eoc) begin
            pixel_idx <= pixel_idx + 1'b1;
            row_clk   <= 1'b1;
            skip_cnt  <= skip_lat;
            step      <= '0;
            state     <= SKIP;
            sig_out   <= pat_col(PH_SKIP, '0);
          end else if (tmo == TMO_W'(EOC_TIMEOUT - 1)) begin
            eoc_err <= 1'b1;
            state   <= IDLE;
            sig_out <= IDLE_LEVEL;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          frame_done <= 1'b1;
          sig_out    <= IDLE_LEVEL;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
